// File: rtl/m1reset_pkg.sv
// Shared definitions for the SoC reset sequencer: FSM encodings, per-channel
// delay extraction and elaboration-time parameter validation.
package m1reset_pkg;

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // Widest packed delay vector supported: 16 channels of up to 32 bits.
  localparam int MAX_DELAY_BITS = 512;

  function automatic logic [31:0] chan_delay(input logic [MAX_DELAY_BITS-1:0] delays,
                                             input int idx, input int cw);
    logic [31:0] mask;
    logic [31:0] raw;
    mask = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    raw  = 32'(delays >> (idx * cw));
    return raw & mask;
  endfunction

  function automatic bit params_ok(input int nchan, input int cw, input bit hold_nz,
                                   input int chan_hold, input int sync_stages);
    return (nchan >= 1) && (nchan <= 16) && (cw >= 1) && (cw <= 32) && hold_nz &&
           (chan_hold >= 1) && (sync_stages >= 2);
  endfunction

endpackage

// File: rtl/m1reset_sync.sv
// Multi-stage synchroniser for asynchronous level inputs, cleared to zero by
// the asynchronous system reset.
module m1reset_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] ff_r;

  // Shift the async input through the synchroniser chain
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ff_r <= '0;
    end else begin
      ff_r <= {ff_r[STAGES-2:0], d};
    end
  end

  assign q = ff_r[STAGES-1];

endmodule

// File: rtl/m1reset_seq.sv
// Reset sequencer: holds all channels after a trigger, releases them at their
// programmed offsets, and supports independent per-channel re-pulses.
module m1reset_seq
  import m1reset_pkg::*;
#(
  parameter int                  NCHAN       = 4,
  parameter int                  CW          = 20,
  parameter logic [CW-1:0]       HOLD_CYCLES = 20'hFFFFF,
  parameter logic [NCHAN*CW-1:0] DELAYS      = {20'd48, 20'd32, 20'd16, 20'd0},
  parameter logic [NCHAN-1:0]    ACTIVE_LOW  = 4'b0000,
  parameter int                  CHAN_HOLD   = 128,
  parameter int                  SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             trigger_reset,
  input  logic [NCHAN-1:0] chan_req,
  output logic [NCHAN-1:0] rst_out,
  output logic             all_released
);

  localparam int            PW         = $clog2(CHAN_HOLD + 1);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(CHAN_HOLD);
  localparam logic [CW-1:0] HOLD_LOAD  = HOLD_CYCLES - CW'(1'b1);
  localparam logic [CW-1:0] SEQ_MAX    = {CW{1'b1}};

  if (!params_ok(NCHAN, CW, (HOLD_CYCLES != '0), CHAN_HOLD, SYNC_STAGES)) begin : g_bad_params
    $error("m1reset_seq: illegal parameter combination");
  end

  logic             trg_s;
  logic [NCHAN-1:0] req_s;
  logic [NCHAN-1:0] req_d_r;
  logic [NCHAN-1:0] req_rise_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CW-1:0]    hold_cnt_r;
  logic [CW-1:0]    seq_r;
  logic [NCHAN-1:0] rel_r;
  logic [NCHAN-1:0] rel_nxt_s;
  logic [NCHAN-1:0] due_s;
  logic [NCHAN-1:0] pulse_act_s;
  logic             all_released_r;

  m1reset_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_trg (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d         (trigger_reset),
    .q         (trg_s)
  );

  m1reset_sync #(.WIDTH(NCHAN), .STAGES(SYNC_STAGES)) u_sync_req (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d         (chan_req),
    .q         (req_s)
  );

  assign req_rise_s = req_s & ~req_d_r;

  // Next-state and release-mask decode; a synced trigger overrides everything
  always_comb begin
    state_nxt_s = state_r;
    rel_nxt_s   = rel_r;
    if (trg_s) begin
      state_nxt_s = ST_HOLD;
      rel_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          rel_nxt_s = '0;
          if (hold_cnt_r == '0) begin
            state_nxt_s = ST_RELEASE;
          end else begin
            state_nxt_s = ST_HOLD;
          end
        end
        ST_RELEASE: begin
          rel_nxt_s = rel_r | due_s;
          if (&(rel_r | due_s)) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_RELEASE;
          end
        end
        ST_RUN: begin
          rel_nxt_s   = rel_r;
          state_nxt_s = ST_RUN;
        end
        default: begin
          rel_nxt_s   = '0;
          state_nxt_s = ST_HOLD;
        end
      endcase
    end
  end

  // FSM state, hold/sequence counters and the release summary flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r        <= ST_HOLD;
      hold_cnt_r     <= HOLD_LOAD;
      seq_r          <= '0;
      rel_r          <= '0;
      req_d_r        <= '0;
      all_released_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      rel_r          <= rel_nxt_s;
      req_d_r        <= req_s;
      all_released_r <= (state_r == ST_RUN) && (pulse_act_s == '0);
      if (trg_s) begin
        hold_cnt_r <= HOLD_LOAD;
      end else if ((state_r == ST_HOLD) && (hold_cnt_r != '0)) begin
        hold_cnt_r <= hold_cnt_r - CW'(1'b1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      if (trg_s || (state_r == ST_HOLD)) begin
        seq_r <= '0;
      end else if ((state_r == ST_RELEASE) && (seq_r != SEQ_MAX)) begin
        seq_r <= seq_r + CW'(1'b1);
      end else begin
        seq_r <= seq_r;
      end
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    localparam logic [CW-1:0] DLY = CW'(chan_delay(MAX_DELAY_BITS'(DELAYS), i, CW));

    logic [PW-1:0] cnt_r;
    logic          out_r;

    assign due_s[i]       = (seq_r >= DLY);
    assign pulse_act_s[i] = (cnt_r != '0);

    // Re-pulse counter (new edge wins over expiry) and the registered output
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        cnt_r <= '0;
        out_r <= ~ACTIVE_LOW[i];
      end else begin
        if (trg_s) begin
          cnt_r <= '0;
        end else if (req_rise_s[i] && rel_r[i] && (state_r != ST_HOLD)) begin
          cnt_r <= PULSE_LOAD;
        end else if (pulse_act_s[i]) begin
          cnt_r <= cnt_r - PW'(1'b1);
        end else begin
          cnt_r <= cnt_r;
        end
        out_r <= ((state_r == ST_HOLD) || !(rel_r[i] || due_s[i]) || pulse_act_s[i])
                 ^ ACTIVE_LOW[i];
      end
    end

    assign rst_out[i] = out_r;
  end

  assign all_released = all_released_r;

endmodule

// File: tb/tb_m1reset_seq.sv
// Scoreboard bench for m1reset_seq: expected {all_released, rst_out} per cycle
// is derived from the documented release timing and compared after each edge.
module tb_m1reset_seq;

  localparam logic [2:0] AL = 3'b101;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       trigger_reset;
  logic [2:0] chan_req;
  logic [2:0] rst_out;
  logic       all_released;

  int vectors     = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  always #5 sys_clk = ~sys_clk;

  m1reset_seq #(
    .NCHAN       (3),
    .CW          (8),
    .HOLD_CYCLES (8'd16),
    .DELAYS      ({8'd8, 8'd4, 8'd0}),
    .ACTIVE_LOW  (AL),
    .CHAN_HOLD   (8),
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .trigger_reset (trigger_reset),
    .chan_req      (chan_req),
    .rst_out       (rst_out),
    .all_released  (all_released)
  );

  // asrt bit i = 1 means channel i is logically in reset
  function automatic logic [3:0] pack_exp(input logic [2:0] asrt, input logic ar);
    return {ar, asrt ^ AL};
  endfunction

  // Power-on timing: k = edges after the last hold reload
  function automatic logic [3:0] por_exp(input int k);
    return pack_exp({k < 25, k < 21, k < 17}, k >= 26);
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: observed %b required %b", tag, obs, exp_v);
    end
  endtask

  task automatic pop_check(input string tag);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      chk(tag, {all_released, rst_out}, exp_q.pop_front());
    end
  endtask

  task automatic cycle(input string tag, input int k, input logic [3:0] e);
    exp_q.push_back(e);
    @(posedge sys_clk);
    #1;
    pop_check($sformatf("%s k=%0d", tag, k));
  endtask

  task automatic do_async_reset(input string tag);
    sys_rst_n = 1'b0;
    #1;
    exp_q.push_back(pack_exp(3'b111, 1'b0));
    pop_check(tag);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    sys_rst_n     = 1'b0;
    trigger_reset = 1'b0;
    chan_req      = 3'b000;
    repeat (3) @(posedge sys_clk);
    #1;
    exp_q.push_back(pack_exp(3'b111, 1'b0));
    pop_check("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    for (int k = 1; k <= 30; k++) cycle("por", k, por_exp(k));

    // Single channel pulse in RUN
    for (int k = 1; k <= 20; k++) begin
      if (k == 1)  chan_req[1] = 1'b1;
      if (k == 14) chan_req[1] = 1'b0;
      a = (k >= 4) && (k <= 11);
      cycle("pulse", k, pack_exp({1'b0, a, 1'b0}, !a));
    end

    // Second edge mid-pulse restarts the count
    for (int k = 1; k <= 20; k++) begin
      if (k == 1)  chan_req[1] = 1'b1;
      if (k == 3)  chan_req[1] = 1'b0;
      if (k == 5)  chan_req[1] = 1'b1;
      if (k == 18) chan_req[1] = 1'b0;
      a = (k >= 4) && (k <= 15);
      cycle("restart", k, pack_exp({1'b0, a, 1'b0}, !a));
    end

    // Trigger held for 100 cycles; synced fall lands on edge 102
    for (int k = 1; k <= 130; k++) begin
      if (k == 1)   trigger_reset = 1'b1;
      if (k == 101) trigger_reset = 1'b0;
      cycle("trig_hold", k, (k < 4) ? pack_exp(3'b000, 1'b1) : por_exp(k - 102));
    end

    // Async reset in RUN; requests in HOLD / before release are ignored
    do_async_reset("async_run");
    for (int k = 1; k <= 30; k++) begin
      if (k == 5)  chan_req[0] = 1'b1;
      if (k == 20) chan_req[2] = 1'b1;
      if (k == 28) chan_req = 3'b000;
      cycle("por_again", k, por_exp(k));
    end

    // One-cycle trigger just after ch0 releases
    do_async_reset("async_rel");
    for (int k = 1; k <= 50; k++) begin
      if (k == 19) trigger_reset = 1'b1;
      if (k == 20) trigger_reset = 1'b0;
      cycle("trig_rel", k, (k < 22) ? por_exp(k) : por_exp(k - 21));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
